multdiv_param: RTL and testbench

Parametrised HI/LO multiply/divide unit for the pipelined MIPS core. It is the next generation of the fixed-32-bit multdiv unit and adds:
- configurable width and multiply latency
- a true iterative radix-2 divider
- multiply-accumulate modes (madd/msub)
- defined divide-by-zero behaviour
- a clean abort on reset

It sits beside the ALU in EX. Decode stalls any mf/mt/md instruction while busy is high.

---
 rtl/multdiv_param.sv | 153 +++++++++++++++
 tb/tb_multdiv_param.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_param.sv
// HI/LO multiply/divide unit for the EX stage. It provides fixed-latency multiply and
// multiply-accumulate, radix-2 restoring divide, and mthi/mtlo writes.
module multdiv_param #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       mdctr,
  input  logic             start,
  input  logic             hiwrite,
  input  logic             lowrite,
  output logic             busy,
  output logic [WIDTH-1:0] hio,
  output logic [WIDTH-1:0] loo,
  output logic             dz
);

  localparam int unsigned CNT_MAX = (MUL_LAT > WIDTH + 1) ? MUL_LAT : WIDTH + 1;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned PW      = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;

  logic             op_signed;
  logic [PW-1:0]    ext_a, ext_b, prod, acc, mres;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign busy = busy_q;
  assign hio  = hi_q;
  assign loo  = lo_q;
  assign dz   = dz_q;

  // Next-state, datapath and commit logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;

    op_signed = ~op_q[0];
    ext_a = op_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b = op_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ext_a * ext_b;
    acc   = {hi_q, lo_q};
    mres  = op_q[2] ? (op_q[1] ? acc - prod : acc + prod) : prod;

    // Dividend bits shift out of quo_q into the partial remainder as quotient bits shift in.
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    q_fix = (op_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
    r_fix = (op_signed && a_q[WIDTH-1]) ? -rem_q : rem_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = CW'(1);
          op_d    = mdctr;
          a_d     = A;
          b_d     = B;
          rem_d   = '0;
          quo_d   = (~mdctr[0] && A[WIDTH-1]) ? -A : A;
          dvs_d   = (~mdctr[0] && B[WIDTH-1]) ? -B : B;
          state_d = (mdctr[2:1] == 2'b01) ? S_DIV : S_MUL;
        end else begin
          if (hiwrite) hi_d = A;
          if (lowrite) lo_d = A;
        end
      end
      S_MUL: begin
        if (cnt_q == CW'(MUL_LAT)) begin
          hi_d    = mres[PW-1:WIDTH];
          lo_d    = mres[WIDTH-1:0];
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == CW'(WIDTH + 1)) begin
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
            dz_d = 1'b1;
          end else begin
            lo_d = q_fix;
            hi_d = r_fix;
            dz_d = 1'b0;
          end
          state_d = S_IDLE;
        end else begin
          rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_multdiv_param.sv
// Scoreboard bench for multdiv_param: a 32-bit/5-cycle instance and an 8-bit/1-cycle instance.
module tb_multdiv_param;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  typedef struct {
    int          kind;  // 0 = start op, 1 = mt write (o[1]=mthi, o[0]=mtlo)
    logic [2:0]  o;
    logic [31:0] av;
    logic [31:0] bv;
  } op_t;

  logic        clk = 1'b0;
  logic        rst32, rst8, st32, st8, hw32, hw8, lw32, lw8;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        busy32, busy8, dz32, dz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  exp_t        q32[$];
  exp_t        q8[$];
  logic [31:0] mhi[2];
  logic [31:0] mlo[2];
  logic        mdz[2];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  multdiv_param #(.WIDTH(32), .MUL_LAT(5)) dut32 (
    .clk(clk), .rst(rst32), .A(a), .B(b), .mdctr(op), .start(st32),
    .hiwrite(hw32), .lowrite(lw32), .busy(busy32), .hio(hi32), .loo(lo32), .dz(dz32)
  );

  multdiv_param #(.WIDTH(8), .MUL_LAT(1)) dut8 (
    .clk(clk), .rst(rst8), .A(a[7:0]), .B(b[7:0]), .mdctr(op), .start(st8),
    .hiwrite(hw8), .lowrite(lw8), .busy(busy8), .hio(hi8), .loo(lo8), .dz(dz8)
  );

  // Reference model built on 64-bit integer arithmetic.
  function automatic exp_t model(input int w, input int mlat, input logic [2:0] o,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] hi, input logic [31:0] lo, input logic dzo);
    exp_t        e;
    longint      m, ua, ub, sa, sb, x, y, prod, qq, rr;
    logic [63:0] acc, res, m2;
    m  = longint'((64'd1 << w) - 64'd1);
    ua = {32'b0, av} & m;
    ub = {32'b0, bv} & m;
    sa = av[w-1] ? ua - (m + 1) : ua;
    sb = bv[w-1] ? ub - (m + 1) : ub;
    e.dz = dzo;
    if (o[2:1] == 2'b01) begin
      e.lat = w + 1;
      if (ub == 0) begin
        e.lo = 32'(m);
        e.hi = 32'(ua);
        e.dz = 1'b1;
      end else begin
        if (!o[0]) begin
          qq = sa / sb;
          rr = sa % sb;
        end else begin
          qq = ua / ub;
          rr = ua % ub;
        end
        e.lo = 32'(qq & m);
        e.hi = 32'(rr & m);
        e.dz = 1'b0;
      end
    end else begin
      e.lat = mlat;
      x     = o[0] ? ua : sa;
      y     = o[0] ? ub : sb;
      prod  = x * y;
      m2    = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
      acc   = ({32'b0, hi} << w) | {32'b0, lo};
      res   = o[2] ? (o[1] ? acc - 64'(prod) : acc + 64'(prod)) : 64'(prod);
      res   = res & m2;
      e.hi  = 32'((res >> w) & 64'(m));
      e.lo  = 32'(res & 64'(m));
    end
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one start cycle; when push is set the expected commit goes on the scoreboard.
  task automatic launch(input int inst, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input bit push, input bit hwr);
    exp_t e;
    a  = av;
    b  = bv;
    op = o;
    if (inst == 0) begin
      st32 = 1'b1;
      hw32 = hwr;
    end else begin
      st8 = 1'b1;
      hw8 = hwr;
    end
    if (push) begin
      e = model(inst == 0 ? 32 : 8, inst == 0 ? 5 : 1, o, av, bv, mhi[inst], mlo[inst], mdz[inst]);
      if (inst == 0) q32.push_back(e);
      else q8.push_back(e);
      mhi[inst] = e.hi;
      mlo[inst] = e.lo;
      mdz[inst] = e.dz;
    end
    cyc();
    st32 = 1'b0; st8 = 1'b0; hw32 = 1'b0; hw8 = 1'b0;
  endtask

  // Count busy cycles (bounded) and note whether hio/loo stayed put meanwhile.
  task automatic wait_idle(input int inst, output int n, output bit held);
    logic [31:0] h0, l0, h, l;
    logic        bz;
    h0 = (inst == 0) ? hi32 : {24'b0, hi8};
    l0 = (inst == 0) ? lo32 : {24'b0, lo8};
    n = 0;
    held = 1'b1;
    bz = (inst == 0) ? busy32 : busy8;
    while (bz && n < 200) begin
      h = (inst == 0) ? hi32 : {24'b0, hi8};
      l = (inst == 0) ? lo32 : {24'b0, lo8};
      if (h !== h0 || l !== l0) held = 1'b0;
      cyc();
      n++;
      bz = (inst == 0) ? busy32 : busy8;
    end
  endtask

  task automatic test_reset();
    rst32 = 1'b1; rst8 = 1'b1;
    st32 = 1'b0; st8 = 1'b0; hw32 = 1'b0; hw8 = 1'b0; lw32 = 1'b0; lw8 = 1'b0;
    a = '0; b = '0; op = '0;
    cyc(); cyc();
    rst32 = 1'b0; rst8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mhi[i] = '0; mlo[i] = '0; mdz[i] = 1'b0;
    end
    total_cnt++;
    if ({busy32, dz32, hi32, lo32} !== 66'b0) $display("FAIL reset32: got busy=%b dz=%b hi=%h lo=%h exp all zero", busy32, dz32, hi32, lo32);
    else pass_cnt++;
    total_cnt++;
    if ({busy8, dz8, hi8, lo8} !== 18'b0) $display("FAIL reset8: got busy=%b dz=%b hi=%h lo=%h exp all zero", busy8, dz8, hi8, lo8);
    else pass_cnt++;
  endtask

  // Runs a table of ops/mt writes against one instance, checking every commit from the scoreboard.
  task automatic test_sequence(input string name, input int inst, input op_t ops[$]);
    exp_t        e;
    int          n;
    bit          held;
    logic [31:0] gh, gl, mk;
    logic        gd;
    mk = (inst == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    foreach (ops[i]) begin
      if (ops[i].kind == 1) begin
        a = ops[i].av;
        if (inst == 0) begin hw32 = ops[i].o[1]; lw32 = ops[i].o[0]; end
        else begin hw8 = ops[i].o[1]; lw8 = ops[i].o[0]; end
        cyc();
        hw32 = 1'b0; lw32 = 1'b0; hw8 = 1'b0; lw8 = 1'b0;
        if (ops[i].o[1]) mhi[inst] = ops[i].av & mk;
        if (ops[i].o[0]) mlo[inst] = ops[i].av & mk;
        gh = (inst == 0) ? hi32 : {24'b0, hi8};
        gl = (inst == 0) ? lo32 : {24'b0, lo8};
        total_cnt++;
        if (gh !== mhi[inst] || gl !== mlo[inst])
          $display("FAIL %s[%0d] mt: got hi=%h lo=%h exp hi=%h lo=%h", name, i, gh, gl, mhi[inst], mlo[inst]);
        else pass_cnt++;
      end else begin
        launch(inst, ops[i].o, ops[i].av, ops[i].bv, 1'b1, 1'b0);
        wait_idle(inst, n, held);
        n = n + 0;
        e = (inst == 0) ? q32.pop_front() : q8.pop_front();
        gh = (inst == 0) ? hi32 : {24'b0, hi8};
        gl = (inst == 0) ? lo32 : {24'b0, lo8};
        gd = (inst == 0) ? dz32 : dz8;
        total_cnt++;
        if (n !== e.lat) $display("FAIL %s[%0d] busy_cycles: got %0d exp %0d", name, i, n, e.lat);
        else pass_cnt++;
        total_cnt++;
        if (!held) $display("FAIL %s[%0d] hold_during_busy: got changed exp stable", name, i);
        else pass_cnt++;
        total_cnt++;
        if (gh !== e.hi || gl !== e.lo)
          $display("FAIL %s[%0d] result: got hi=%h lo=%h exp hi=%h lo=%h", name, i, gh, gl, e.hi, e.lo);
        else pass_cnt++;
        total_cnt++;
        if (gd !== e.dz) $display("FAIL %s[%0d] dz: got %b exp %b", name, i, gd, e.dz);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_mult_mac();
    op_t s[$];
    s = '{'{0, 3'b000, 32'hFFFF_FFFD, 32'd7},
          '{0, 3'b001, 32'hFFFF_FFFF, 32'd2},
          '{1, 3'b001, 32'd5, 32'd0},
          '{1, 3'b010, 32'd0, 32'd0},
          '{0, 3'b100, 32'd3, 32'd4},
          '{0, 3'b111, 32'd1, 32'd12},
          '{0, 3'b110, 32'hFFFF_FFFE, 32'd3},
          '{0, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
          '{1, 3'b011, 32'h1234_5678, 32'd0}};
    test_sequence("mult32", 0, s);
  endtask

  task automatic test_div();
    op_t s[$];
    s = '{'{0, 3'b010, 32'hFFFF_FFF9, 32'd2},
          '{0, 3'b011, 32'd7, 32'd2},
          '{0, 3'b011, 32'h0000_0010, 32'd0},
          '{0, 3'b011, 32'd9, 32'd3},
          '{0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF},
          '{0, 3'b010, 32'd7, 32'hFFFF_FFFE},
          '{0, 3'b010, 32'hFFFF_FFF8, 32'd0},
          '{0, 3'b011, 32'hFFFF_FFFF, 32'd10}};
    test_sequence("div32", 0, s);
  endtask

  task automatic test_abort();
    bit ok;
    launch(0, 3'b010, 32'hFFFF_FF9C, 32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc();
    rst32 = 1'b1;
    cyc();
    rst32 = 1'b0;
    mhi[0] = '0; mlo[0] = '0; mdz[0] = 1'b0;
    total_cnt++;
    if ({busy32, dz32, hi32, lo32} !== 66'b0) $display("FAIL abort_reset: got busy=%b dz=%b hi=%h lo=%h exp all zero", busy32, dz32, hi32, lo32);
    else pass_cnt++;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ({busy32, hi32, lo32} !== 65'b0) ok = 1'b0;
      cyc();
    end
    total_cnt++;
    if (!ok) $display("FAIL abort_no_commit: got later activity exp none");
    else pass_cnt++;
  endtask

  task automatic test_ignored_start();
    exp_t e;
    int   n;
    bit   held;
    launch(0, 3'b000, 32'd6, 32'd7, 1'b1, 1'b0);
    cyc(); cyc();
    a = 32'd100; b = 32'd100; op = 3'b011;
    st32 = 1'b1; hw32 = 1'b1; lw32 = 1'b1;
    cyc();
    st32 = 1'b0; hw32 = 1'b0; lw32 = 1'b0;
    wait_idle(0, n, held);
    e = q32.pop_front();
    total_cnt++;
    if (n + 3 !== e.lat) $display("FAIL ignored_start_cycles: got %0d exp %0d", n + 3, e.lat);
    else pass_cnt++;
    total_cnt++;
    if (hi32 !== e.hi || lo32 !== e.lo) $display("FAIL ignored_start_result: got hi=%h lo=%h exp hi=%h lo=%h", hi32, lo32, e.hi, e.lo);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (busy32 !== 1'b0) $display("FAIL ignored_start_relaunch: got busy=%b exp 0", busy32);
    else pass_cnt++;
  endtask

  task automatic test_start_hiwrite();
    exp_t e;
    int   n;
    bit   held;
    launch(0, 3'b000, 32'd2, 32'd2, 1'b1, 1'b1);
    wait_idle(0, n, held);
    e = q32.pop_front();
    total_cnt++;
    if (hi32 !== e.hi || lo32 !== e.lo || hi32 !== 32'd0 || lo32 !== 32'd4)
      $display("FAIL start_with_mthi: got hi=%h lo=%h exp hi=%h lo=%h", hi32, lo32, e.hi, e.lo);
    else pass_cnt++;
  endtask

  task automatic test_width8();
    op_t s[$];
    s = '{'{0, 3'b000, 32'h80, 32'hFF},
          '{0, 3'b010, 32'h80, 32'hFF},
          '{0, 3'b011, 32'hFF, 32'h00},
          '{0, 3'b010, 32'hF9, 32'h02},
          '{0, 3'b001, 32'hFF, 32'hFF},
          '{0, 3'b100, 32'h7F, 32'h81},
          '{1, 3'b011, 32'h5A, 32'd0},
          '{0, 3'b111, 32'h10, 32'h10}};
    test_sequence("w8", 1, s);
  endtask

  initial begin
    test_reset();
    test_mult_mac();
    test_div();
    test_abort();
    test_ignored_start();
    test_start_hiwrite();
    test_width8();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
